// File: rtl/iagc_pkg.sv
// iagc_pkg: shared definitions for the IAGC capture-path controller.
//   - iagc_state_e : controller states; the encoding is the status code driven on the bus
//   - dump_phase_e : sub-steps of one DUMP_MEM word
//   - opcode, ACK/NAK byte constants and an operand range helper
package iagc_pkg;

  typedef enum logic [3:0] {
    StReset    = 4'd0,
    StInit     = 4'd1,
    StIdle     = 4'd2,
    StSample   = 4'd3,
    StCmdParse = 4'd4,
    StCmdRead  = 4'd5,
    StCmdError = 4'd6,
    StDumpMem  = 4'd7,
    StCleanMem = 4'd8,
    StSetMem   = 4'd9,
    StSetDec   = 4'd10
  } iagc_state_e;

  typedef enum logic [2:0] {
    PhAddr,
    PhCap,
    PhHi,
    PhLo,
    PhCks,
    PhAck
  } dump_phase_e;

  localparam logic [7:0] OpSample = 8'h53;
  localparam logic [7:0] OpDump   = 8'h44;
  localparam logic [7:0] OpClean  = 8'h43;
  localparam logic [7:0] OpSetMem = 8'h4D;
  localparam logic [7:0] OpSetDec = 8'h52;
  localparam logic [7:0] OpAbort  = 8'h1B;

  localparam logic [7:0] RespAck = 8'h06;
  localparam logic [7:0] RespNak = 8'h15;

  // True when v lies in 1 .. 2^width-1.
  function automatic logic in_range(logic [15:0] v, int unsigned width);
    return (v != '0) && ((v >> width) == '0);
  endfunction

endpackage

// File: rtl/iagc_tx_byte.sv
// iagc_tx_byte: one-byte holding register towards the serial transmitter.
//   i_load/i_data : capture a byte when no byte is pending
//   o_tx_data     : held stable while o_tx_valid is high
//   o_tx_valid    : drops on the edge where i_tx_ready accepts the byte
module iagc_tx_byte (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_tx_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid
);

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && i_tx_ready) begin
      valid_d = 1'b0;
    end else if (!valid_q && i_load) begin
      valid_d = 1'b1;
      data_d  = i_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_tx_data  = data_q;
  assign o_tx_valid = valid_q;

endmodule

// File: rtl/iagc_controller.sv
// iagc_controller: command sequencer for the IAGC capture path.
//   i_rx_data/i_rx_valid    : command and operand bytes from the serial receiver
//   o_tx_data/o_tx_valid    : response / dump bytes, accepted by i_tx_ready
//   i_sampler_end           : sampler finished a capture
//   o_iagc_status           : current state code
//   o_memory_size/o_decimator : configuration registers
//   o_mem_addr/o_mem_wdata/o_mem_we/i_mem_rdata : sample memory port (dump/clean)
// Optional: define IAGC_DUMP_CHECKSUM_EN to append an XOR checksum byte to dumps.
module iagc_controller
  import iagc_pkg::*;
#(
  parameter int unsigned DATA_SIZE        = 16,
  parameter int unsigned ADDR_SIZE        = 12,
  parameter int unsigned IAGC_STATUS_SIZE = 4,
  parameter int unsigned DECIMATOR_SIZE   = 4,
  parameter int unsigned DEFAULT_MEM_SIZE = 4095,
  parameter int unsigned CMD_TIMEOUT      = 1000000
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [7:0]                  i_rx_data,
  input  logic                        i_rx_valid,
  output logic [7:0]                  o_tx_data,
  output logic                        o_tx_valid,
  input  logic                        i_tx_ready,
  input  logic                        i_sampler_end,
  output logic [IAGC_STATUS_SIZE-1:0] o_iagc_status,
  output logic [ADDR_SIZE-1:0]        o_memory_size,
  output logic [DECIMATOR_SIZE-1:0]   o_decimator,
  output logic [ADDR_SIZE-1:0]        o_mem_addr,
  output logic [DATA_SIZE-1:0]        o_mem_wdata,
  output logic                        o_mem_we,
  input  logic [DATA_SIZE-1:0]        i_mem_rdata
);

  localparam int unsigned TmoW = $clog2(CMD_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(CMD_TIMEOUT - 1);

  iagc_state_e                state_q, state_d;
  dump_phase_e                phase_q, phase_d;
  logic                       resp_q, resp_d;  // byte handed to tx, awaiting acceptance
  logic [7:0]                 opcode_q, opcode_d;
  logic [15:0]                operand_q, operand_d;
  logic [1:0]                 rem_q, rem_d;
  logic [TmoW-1:0]            tmo_q, tmo_d;
  logic [ADDR_SIZE-1:0]       mem_size_q, mem_size_d;
  logic [DECIMATOR_SIZE-1:0]  dec_q, dec_d;
  logic [ADDR_SIZE-1:0]       mem_addr_q, mem_addr_d;
  logic                       mem_we_q, mem_we_d;
  logic [DATA_SIZE-1:0]       rdata_q, rdata_d;
`ifdef IAGC_DUMP_CHECKSUM_EN
  logic [7:0]                 cks_q, cks_d;
`endif

  logic       tx_load;
  logic [7:0] tx_byte;
  logic       tx_accept;
  logic [ADDR_SIZE-1:0] last_addr;

  assign tx_accept = o_tx_valid && i_tx_ready;
  assign last_addr = mem_size_q - ADDR_SIZE'(1);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    resp_d     = resp_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    rem_d      = rem_q;
    tmo_d      = tmo_q;
    mem_size_d = mem_size_q;
    dec_d      = dec_q;
    mem_addr_d = mem_addr_q;
    mem_we_d   = 1'b0;
    rdata_d    = rdata_q;
`ifdef IAGC_DUMP_CHECKSUM_EN
    cks_d      = cks_q;
`endif
    tx_load    = 1'b0;
    tx_byte    = RespAck;

    unique case (state_q)
      StReset: state_d = StInit;
      StInit: begin
        opcode_d  = '0;
        operand_d = '0;
        tmo_d     = '0;
        rem_d     = '0;
        state_d   = StIdle;
      end
      StIdle: begin
        if (i_rx_valid) begin
          opcode_d = i_rx_data;
          state_d  = StCmdParse;
        end
      end
      StCmdParse: begin
        tmo_d     = '0;
        operand_d = '0;
        case (opcode_q)
          OpSample: state_d = StSample;
          OpDump: begin
            state_d    = StDumpMem;
            phase_d    = PhAddr;
            mem_addr_d = '0;
`ifdef IAGC_DUMP_CHECKSUM_EN
            cks_d      = '0;
`endif
          end
          OpClean: begin
            state_d    = StCleanMem;
            mem_addr_d = '0;
            mem_we_d   = 1'b1;
          end
          OpSetMem: begin
            rem_d   = 2'd2;
            state_d = StCmdRead;
          end
          OpSetDec: begin
            rem_d   = 2'd1;
            state_d = StCmdRead;
          end
          default: state_d = StCmdError;
        endcase
      end
      StCmdRead: begin
        if (i_rx_valid) begin
          operand_d = {operand_q[7:0], i_rx_data};
          tmo_d     = '0;
          rem_d     = rem_q - 2'd1;
          if (rem_q == 2'd1) begin
            state_d = (opcode_q == OpSetMem) ? StSetMem : StSetDec;
          end
        end else if (tmo_q == TmoLast) begin
          state_d = StCmdError;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StSetMem: begin
        if (!resp_q) begin
          if (in_range(operand_q, ADDR_SIZE)) begin
            mem_size_d = operand_q[ADDR_SIZE-1:0];
            tx_load    = 1'b1;
            resp_d     = 1'b1;
          end else begin
            state_d = StCmdError;
          end
        end else if (tx_accept) begin
          resp_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StSetDec: begin
        if (!resp_q) begin
          if (in_range(operand_q, DECIMATOR_SIZE)) begin
            dec_d   = operand_q[DECIMATOR_SIZE-1:0];
            tx_load = 1'b1;
            resp_d  = 1'b1;
          end else begin
            state_d = StCmdError;
          end
        end else if (tx_accept) begin
          resp_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StSample: begin
        // Abort wins over a simultaneous capture-complete.
        if (!resp_q) begin
          if (i_rx_valid && (i_rx_data == OpAbort)) begin
            tx_load = 1'b1;
            tx_byte = RespNak;
            resp_d  = 1'b1;
          end else if (i_sampler_end) begin
            tx_load = 1'b1;
            resp_d  = 1'b1;
          end
        end else if (tx_accept) begin
          resp_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StCmdError: begin
        if (!resp_q) begin
          tx_load = 1'b1;
          tx_byte = RespNak;
          resp_d  = 1'b1;
        end else if (tx_accept) begin
          resp_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StCleanMem: begin
        if (mem_we_q) begin
          if (mem_addr_q == last_addr) begin
            mem_addr_d = '0;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_SIZE'(1);
            mem_we_d   = 1'b1;
          end
        end else if (!resp_q) begin
          tx_load = 1'b1;
          resp_d  = 1'b1;
        end else if (tx_accept) begin
          resp_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StDumpMem: begin
        unique case (phase_q)
          PhAddr: phase_d = PhCap;
          // Read data for the address driven last cycle is valid now.
          PhCap: begin
            rdata_d = i_mem_rdata;
            phase_d = PhHi;
          end
          PhHi: begin
            if (!resp_q) begin
              tx_load = 1'b1;
              tx_byte = rdata_q[15:8];
              resp_d  = 1'b1;
`ifdef IAGC_DUMP_CHECKSUM_EN
              cks_d   = cks_q ^ rdata_q[15:8];
`endif
            end else if (tx_accept) begin
              resp_d  = 1'b0;
              phase_d = PhLo;
            end
          end
          PhLo: begin
            if (!resp_q) begin
              tx_load = 1'b1;
              tx_byte = rdata_q[7:0];
              resp_d  = 1'b1;
`ifdef IAGC_DUMP_CHECKSUM_EN
              cks_d   = cks_q ^ rdata_q[7:0];
`endif
            end else if (tx_accept) begin
              resp_d = 1'b0;
              if (mem_addr_q == last_addr) begin
`ifdef IAGC_DUMP_CHECKSUM_EN
                phase_d = PhCks;
`else
                phase_d = PhAck;
`endif
              end else begin
                mem_addr_d = mem_addr_q + ADDR_SIZE'(1);
                phase_d    = PhAddr;
              end
            end
          end
`ifdef IAGC_DUMP_CHECKSUM_EN
          PhCks: begin
            if (!resp_q) begin
              tx_load = 1'b1;
              tx_byte = cks_q;
              resp_d  = 1'b1;
            end else if (tx_accept) begin
              resp_d  = 1'b0;
              phase_d = PhAck;
            end
          end
`endif
          PhAck: begin
            if (!resp_q) begin
              tx_load = 1'b1;
              resp_d  = 1'b1;
            end else if (tx_accept) begin
              resp_d     = 1'b0;
              mem_addr_d = '0;
              state_d    = StIdle;
            end
          end
          default: phase_d = PhAddr;
        endcase
      end
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StReset;
      phase_q    <= PhAddr;
      resp_q     <= 1'b0;
      opcode_q   <= '0;
      operand_q  <= '0;
      rem_q      <= '0;
      tmo_q      <= '0;
      mem_size_q <= ADDR_SIZE'(DEFAULT_MEM_SIZE);
      dec_q      <= DECIMATOR_SIZE'(1);
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      rdata_q    <= '0;
`ifdef IAGC_DUMP_CHECKSUM_EN
      cks_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      resp_q     <= resp_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      rem_q      <= rem_d;
      tmo_q      <= tmo_d;
      mem_size_q <= mem_size_d;
      dec_q      <= dec_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      rdata_q    <= rdata_d;
`ifdef IAGC_DUMP_CHECKSUM_EN
      cks_q      <= cks_d;
`endif
    end
  end

  iagc_tx_byte u_tx_byte (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (tx_load),
    .i_data     (tx_byte),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid)
  );

  assign o_iagc_status = IAGC_STATUS_SIZE'(state_q);
  assign o_memory_size = mem_size_q;
  assign o_decimator   = dec_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_we      = mem_we_q;
  assign o_mem_wdata   = '0;

endmodule

// File: tb/tb_iagc_controller.sv
module tb_iagc_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        sampler_end = 1'b0;
  logic [3:0]  status;
  logic [11:0] mem_size;
  logic [3:0]  dec;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  iagc_controller #(
    .DATA_SIZE        (16),
    .ADDR_SIZE        (12),
    .IAGC_STATUS_SIZE (4),
    .DECIMATOR_SIZE   (4),
    .DEFAULT_MEM_SIZE (4095),
    .CMD_TIMEOUT      (50)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_rx_data     (rx_data),
    .i_rx_valid    (rx_valid),
    .o_tx_data     (tx_data),
    .o_tx_valid    (tx_valid),
    .i_tx_ready    (tx_ready),
    .i_sampler_end (sampler_end),
    .o_iagc_status (status),
    .o_memory_size (mem_size),
    .o_decimator   (dec),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .o_mem_we      (mem_we),
    .i_mem_rdata   (mem_rdata)
  );

  // Sample memory model: 1-cycle read latency, bench preload port has priority.
  logic [15:0] mem [0:4095];
  logic [15:0] exp_mem [0:4095];
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Write log and tx hold monitor, sampled mid-cycle.
  int cyc = 0;
  int n_wr = 0;
  int wr_addr [0:63];
  int wr_data [0:63];
  int wr_cyc  [0:63];
  int hold_viol = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && mem_we && n_wr < 64) begin
      wr_addr[n_wr] <= int'(mem_addr);
      wr_data[n_wr] <= int'(mem_wdata);
      wr_cyc[n_wr]  <= cyc;
      n_wr          <= n_wr + 1;
    end
    if (!rst && prev_valid && !prev_ready && (!tx_valid || tx_data != prev_data))
      hold_viol <= hold_viol + 1;
    prev_valid <= tx_valid && !rst;
    prev_ready <= tx_ready;
    prev_data  <= tx_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_rx(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic preload(input int a, input logic [15:0] d);
    pl_we   = 1'b1;
    pl_addr = 12'(a);
    pl_data = d;
    exp_mem[a] = d;
    tick(1);
    pl_we = 1'b0;
  endtask

  task automatic get_byte(input bit stall, output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = '0;
    for (int i = 0; i < 200; i++) begin
      tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        b  = tx_data;
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    tx_ready = 1'b0;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp, input bit stall);
    logic [7:0] b;
    bit ok;
    get_byte(stall, b, ok);
    check(tag, ok ? {24'h0, b} : 32'hDEAD_BEEF, {24'h0, exp});
  endtask

  task automatic cmd_mem(input string tag, input logic [15:0] v, input logic [7:0] resp);
    send_rx(8'h4D);
    tick(1);
    send_rx(v[15:8]);
    send_rx(v[7:0]);
    expect_byte(tag, resp, 1'b0);
    check({tag, "_idle"}, 32'(status), 32'd2);
  endtask

  task automatic cmd_dec(input string tag, input logic [7:0] v, input logic [7:0] resp);
    send_rx(8'h52);
    tick(1);
    send_rx(v);
    expect_byte(tag, resp, 1'b0);
  endtask

  task automatic dump_check(input string tag, input int n, input bit stall);
    logic [7:0] x;
    x = '0;
    send_rx(8'h44);
    for (int a = 0; a < n; a++) begin
      expect_byte({tag, "_hi"}, exp_mem[a][15:8], stall);
      expect_byte({tag, "_lo"}, exp_mem[a][7:0], stall);
      x = x ^ exp_mem[a][15:8] ^ exp_mem[a][7:0];
    end
`ifdef IAGC_DUMP_CHECKSUM_EN
    expect_byte({tag, "_cks"}, x, stall);
`endif
    expect_byte({tag, "_ack"}, 8'h06, stall);
    check({tag, "_idle"}, 32'(status), 32'd2);
    check({tag, "_addr0"}, 32'(mem_addr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n5;
    // Reset and startup sequence.
    tick(3);
    check("rst_status", 32'(status), 32'd0);
    check("rst_memsize", 32'(mem_size), 32'd4095);
    check("rst_dec", 32'(dec), 32'd1);
    check("rst_txvalid", 32'(tx_valid), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    rst = 1'b0;
    check("rel_status0", 32'(status), 32'd0);
    tick(1);
    check("rel_status1", 32'(status), 32'd1);
    tick(1);
    check("rel_status2", 32'(status), 32'd2);

    // Memory-size configuration.
    cmd_mem("setmem8", 16'h0008, 8'h06);
    check("memsize8", 32'(mem_size), 32'd8);
    cmd_mem("setmem0", 16'h0000, 8'h15);
    check("memsize_keep0", 32'(mem_size), 32'd8);
    cmd_mem("setmem4096", 16'h1000, 8'h15);
    check("memsize_keep4096", 32'(mem_size), 32'd8);

    // Dump two words with random tx stalls.
    preload(0, 16'h1234);
    preload(1, 16'hABCD);
    preload(4, 16'h5555);
    cmd_mem("setmem2", 16'h0002, 8'h06);
    dump_check("dump2", 2, 1'b1);
    check("tx_hold", 32'(hold_viol), 32'd0);

    // Sample complete and sample abort.
    send_rx(8'h53);
    tick(3);
    check("sample_status", 32'(status), 32'd3);
    check("sample_addr", 32'(mem_addr), 32'd0);
    sampler_end = 1'b1;
    tick(1);
    sampler_end = 1'b0;
    expect_byte("sample_ack", 8'h06, 1'b0);
    check("sample_idle", 32'(status), 32'd2);
    send_rx(8'h53);
    tick(2);
    send_rx(8'h41);
    check("sample_drop", 32'(status), 32'd3);
    send_rx(8'h1B);
    expect_byte("abort_nak", 8'h15, 1'b0);
    check("abort_idle", 32'(status), 32'd2);

    // Decimator configuration, range and timeout.
    cmd_dec("setdec3", 8'h03, 8'h06);
    check("dec3", 32'(dec), 32'd3);
    cmd_dec("setdec16", 8'h10, 8'h15);
    check("dec_keep16", 32'(dec), 32'd3);
    send_rx(8'h52);
    n5 = 0;
    for (int i = 0; i < 200 && status != 4'd6; i++) begin
      if (status == 4'd5) n5++;
      tick(1);
    end
    check("tmo_status", 32'(status), 32'd6);
    check("tmo_cycles", 32'(n5), 32'd50);
    expect_byte("tmo_nak", 8'h15, 1'b0);
    check("tmo_dec", 32'(dec), 32'd3);

    // Unknown opcode.
    send_rx(8'h5A);
    expect_byte("bad_op_nak", 8'h15, 1'b0);

    // Clean four words.
    preload(2, 16'h7777);
    preload(3, 16'h8888);
    cmd_mem("setmem4", 16'h0004, 8'h06);
    base = n_wr;
    send_rx(8'h43);
    expect_byte("clean_ack", 8'h06, 1'b0);
    check("clean_nwr", 32'(n_wr - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("clean_addr", 32'(wr_addr[base + i]), 32'(i));
      check("clean_data", 32'(wr_data[base + i]), 32'd0);
      check("clean_cyc", 32'(wr_cyc[base + i] - wr_cyc[base]), 32'(i));
      exp_mem[i] = 16'h0000;
    end
    check("clean_keep4", 32'(mem[4]), 32'h5555);
    check("clean_we_off", 32'(mem_we), 32'd0);

    // Boundary: single-word dump.
    preload(0, 16'hC3A5);
    cmd_mem("setmem1", 16'h0001, 8'h06);
    dump_check("dump1", 1, 1'b0);

    // Reset in the middle of a clean.
    cmd_mem("setmem4b", 16'h0004, 8'h06);
    send_rx(8'h43);
    tick(1);
    check("midclean_we", 32'(mem_we), 32'd1);
    check("midclean_status", 32'(status), 32'd8);
    rst = 1'b1;
    #1;
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_status", 32'(status), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_memsize", 32'(mem_size), 32'd4095);
    tick(2);
    rst = 1'b0;
    tick(2);
    check("arst_idle", 32'(status), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
